vctrl_access_arbiter: RTL and testbench
=======================================

// Module: vctrl_access_arbiter
// PURPOSE
//  Shares the single read port (a) and single write port (c) of the vector control
//  register file between NUMREQ requesters, e.g. scalar-core vctrl moves, vector-unit
//  vl updates and matmul mask setup. Round-robin, one access per cycle, optional
//  bounded lock for read-modify-write sequences. Sits directly in front of the
//  control register file; its rf_* ports connect straight to the file's a/c ports.
// PARAMETERS
//  WIDTH        32  data width of the control registers
//  LOG2NUMREGS  5   register index width
//  NUMREQ       3   number of requesters
//  LOG2NUMREQ   2   width of the round-robin pointer and lock owner
//  LOCK_MAX     8   max consecutive grants a locked requester may hold (>=2)
// PORTS
//  clk              in   1                    clock
//  reset            in   1                    asynchronous, active-high reset
//  req_valid        in   NUMREQ               request present, one bit per requester
//  req_we           in   NUMREQ               1=write, 0=read
//  req_lock         in   NUMREQ               keep grant after this access
//  req_reg          in   NUMREQ*LOG2NUMREGS   register index, requester i at [i*L+:L]
//  req_wdata        in   NUMREQ*WIDTH         write data, requester i at [i*WIDTH+:WIDTH]
//  req_ready        out  NUMREQ               one-hot grant; handshake = valid & ready
//  rsp_valid        out  NUMREQ               one-hot read response strobe
//  rsp_data         out  WIDTH                read data, valid when any rsp_valid bit is set
//  rf_a_reg         out  LOG2NUMREGS          register file read address
//  rf_a_en          out  1                    register file read enable
//  rf_a_readdataout in   WIDTH                register file read data (one-cycle latency)
//  rf_c_reg         out  LOG2NUMREGS          register file write address
//  rf_c_writedatain out  WIDTH                register file write data
//  rf_c_we          out  1                    register file write enable
// BEHAVIOUR
//  - Reset (async, active-high): rr_ptr=0, lock_active=0, lock_cnt=0,
//    rsp_valid=0, rsp_data=0. rf_* outputs are 0 while no request is present.
//  - Grant (combinational):
//    - If lock_active, grant the lock owner only, whether or not it requests.
//    - Otherwise grant the first requester with req_valid=1 at or after rr_ptr,
//      wrapping modulo NUMREQ.
//    - req_ready is asserted only to a requester whose req_valid is 1; at most one bit.
//  - Accept cycle t (req_valid[g] & req_ready[g]):
//    - Write: rf_c_we=1, rf_c_reg and rf_c_writedatain taken from requester g in cycle t.
//    - Read: rf_a_en=1, rf_a_reg from requester g in cycle t. At t+1,
//      rsp_valid[g]=1 for exactly one cycle and rsp_data=rf_a_readdataout.
//      Reads issue back-to-back with no bubble.
//  - rr_ptr is updated on every unlocked accept to (g+1) mod NUMREQ. It is held while
//    lock_active=1.
//  - Lock:
//    - An accept with req_lock[g]=1 sets lock_active=1 and owner=g, and increments lock_cnt.
//    - An owner accept with req_lock=0 clears the lock. rr_ptr is then set to owner+1.
//    - The owner idling (req_valid=0) keeps the lock; other requesters stall.
//    - When lock_cnt reaches LOCK_MAX the lock force-clears at the next edge, even if
//      req_lock=1. rr_ptr is set to owner+1 and lock_cnt returns to 0.
//    - No new lock is granted to the same requester in the cycle of a forced release.
//  - Hazards:
//    - Only one access is issued per cycle, so there is never a same-cycle
//      read/write address conflict.
//    - A write at t followed by a read of the same register at t+1 returns the new value.
//  - A write never produces an rsp_valid pulse.
//  - Reset mid-read: the pending response is dropped (rsp_valid=0) and the lock is
//    released. A requester must not expect a response for a read accepted before reset.
// TESTING
//  1. Writes: write r0=0x40 from req0, then r31=0x5 from req1 -> rf_c_we pulses in
//     consecutive cycles with matching reg/data; no rsp_valid.
//  2. Read-after-write: req0 writes r2=0xDEAD at t, reads r2 at t+1 ->
//     rsp_valid=3'b001 at t+2 with rsp_data=0xDEAD.
//  3. All three requesters hold reads of r1,r2,r3 with rr_ptr=0 -> grants
//     001,010,100,001 in successive cycles; each response arrives one cycle after
//     its grant.
//  4. Lock: req1 reads r29 with lock=1 while req0 and req2 wait, stays idle for 2 cycles,
//     then writes r29 with lock=0 -> req0 and req2 are not granted before the write
//     completes; the next grant goes to req2.
//  5. Lock timeout: req2 holds req_lock=1 continuously with LOCK_MAX=8 -> exactly 8
//     grants to req2, then the lock force-releases and req0 is granted next.
//  6. Reset asserted the cycle after a read is accepted -> rsp_valid stays 0,
//     rr_ptr=0 and lock cleared immediately (asynchronously).

Source files
------------

// File: rtl/vctrl_access_arbiter_if.sv
// Bundle of the requester handshake signals and the control register file
// a (read) / c (write) port signals handled by vctrl_access_arbiter.
//   slave  : arbiter view (takes requests and read data, drives grants,
//            responses and register file controls)
//   master : requester / register file view (the opposite directions)
// Packed request fields hold requester i at [i*LOG2NUMREGS +: LOG2NUMREGS]
// and [i*WIDTH +: WIDTH].
interface vctrl_access_arbiter_if #(
    parameter int WIDTH       = 32,
    parameter int LOG2NUMREGS = 5,
    parameter int NUMREQ      = 3
) ();
    logic [NUMREQ-1:0]             req_valid;
    logic [NUMREQ-1:0]             req_we;
    logic [NUMREQ-1:0]             req_lock;
    logic [NUMREQ*LOG2NUMREGS-1:0] req_reg;
    logic [NUMREQ*WIDTH-1:0]       req_wdata;
    logic [NUMREQ-1:0]             req_ready;
    logic [NUMREQ-1:0]             rsp_valid;
    logic [WIDTH-1:0]              rsp_data;
    logic [LOG2NUMREGS-1:0]        rf_a_reg;
    logic                          rf_a_en;
    logic [WIDTH-1:0]              rf_a_readdataout;
    logic [LOG2NUMREGS-1:0]        rf_c_reg;
    logic [WIDTH-1:0]              rf_c_writedatain;
    logic                          rf_c_we;

    modport slave (
        input  req_valid, req_we, req_lock, req_reg, req_wdata, rf_a_readdataout,
        output req_ready, rsp_valid, rsp_data,
               rf_a_reg, rf_a_en, rf_c_reg, rf_c_writedatain, rf_c_we
    );

    modport master (
        output req_valid, req_we, req_lock, req_reg, req_wdata, rf_a_readdataout,
        input  req_ready, rsp_valid, rsp_data,
               rf_a_reg, rf_a_en, rf_c_reg, rf_c_writedatain, rf_c_we
    );
endinterface

// File: rtl/vctrl_access_arbiter.sv
// Round-robin arbiter sharing the single read port (a) and write port (c) of
// the vector control register file among NUMREQ requesters. One access per
// cycle; a requester may hold a bounded lock (at most LOCK_MAX consecutive
// grants) for read-modify-write sequences.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : vctrl_access_arbiter_if.slave -- requests (valid/we/lock/reg/wdata),
//           grants (req_ready), read responses (rsp_valid/rsp_data) and the
//           register file a/c port signals (rf_*).
module vctrl_access_arbiter #(
    parameter int WIDTH       = 32,
    parameter int LOG2NUMREGS = 5,
    parameter int NUMREQ      = 3,
    parameter int LOG2NUMREQ  = 2,
    parameter int LOCK_MAX    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    vctrl_access_arbiter_if.slave  bus
);

    localparam int CNTW = $clog2(LOCK_MAX + 1);
    localparam logic [CNTW-1:0]       CNT_LAST = CNTW'(LOCK_MAX - 1);
    localparam logic [LOG2NUMREQ-1:0] IDX_LAST = LOG2NUMREQ'(NUMREQ - 1);

    typedef enum logic {S_OPEN, S_LOCKED} state_t;

    state_t                  state, state_next;
    logic [LOG2NUMREQ-1:0]   rr_ptr;
    logic [LOG2NUMREQ-1:0]   lock_owner;
    logic [CNTW-1:0]         lock_cnt;
    logic [NUMREQ-1:0]       rsp_valid_q;

    logic                    grant_found;
    logic [LOG2NUMREQ-1:0]   grant_idx;
    logic [LOG2NUMREQ-1:0]   grant_next;
    logic [LOG2NUMREQ-1:0]   cand_idx;
    int unsigned             cand;
    logic                    accept;
    logic                    sel_we;
    logic                    sel_lock;
    logic                    release_lock;

    logic [LOG2NUMREGS-1:0]  reg_arr   [NUMREQ];
    logic [WIDTH-1:0]        wdata_arr [NUMREQ];

    for (genvar gi = 0; gi < NUMREQ; gi++) begin : g_unpack
        assign reg_arr[gi]   = bus.req_reg[gi*LOG2NUMREGS +: LOG2NUMREGS];
        assign wdata_arr[gi] = bus.req_wdata[gi*WIDTH +: WIDTH];
    end

    // Arbitration: a lock owner is the only candidate; otherwise first valid
    // requester scanning upward from rr_ptr with wrap.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        if (state == S_LOCKED) begin
            if (bus.req_valid[lock_owner]) begin
                grant_found = 1'b1;
                grant_idx   = lock_owner;
            end
        end else begin
            for (int unsigned i = 0; i < NUMREQ; i++) begin
                cand     = (32'(rr_ptr) + i) % NUMREQ;
                cand_idx = LOG2NUMREQ'(cand);
                if (!grant_found && bus.req_valid[cand_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end
    end

    assign accept     = grant_found;
    assign sel_we     = bus.req_we[grant_idx];
    assign sel_lock   = bus.req_lock[grant_idx];
    assign grant_next = (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;

    // Release on the owner's LOCK_MAX-th grant: the counter would reach
    // LOCK_MAX at this edge, so it returns straight to 0 instead, and the
    // same accept cannot open a fresh lock.
    assign release_lock = accept && (state == S_LOCKED) &&
                          (!sel_lock || (lock_cnt == CNT_LAST));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_OPEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_OPEN:   if (accept && sel_lock) state_next = S_LOCKED;
            S_LOCKED: if (release_lock)       state_next = S_OPEN;
            default:  state_next = S_OPEN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            lock_owner  <= '0;
            lock_cnt    <= '0;
            rsp_valid_q <= '0;
        end else begin
            rsp_valid_q <= (accept && !sel_we) ? bus.req_ready : '0;
            if (accept) begin
                if (state == S_OPEN) begin
                    rr_ptr <= grant_next;
                    if (sel_lock) begin
                        lock_owner <= grant_idx;
                        lock_cnt   <= CNTW'(1);
                    end
                end else if (release_lock) begin
                    // grant_idx equals lock_owner here, so this is owner+1.
                    rr_ptr   <= grant_next;
                    lock_cnt <= '0;
                end else begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.req_ready        = '0;
        bus.rf_a_en          = 1'b0;
        bus.rf_a_reg         = '0;
        bus.rf_c_we          = 1'b0;
        bus.rf_c_reg         = '0;
        bus.rf_c_writedatain = '0;
        if (accept) begin
            bus.req_ready = NUMREQ'(1) << grant_idx;
            if (sel_we) begin
                bus.rf_c_we          = 1'b1;
                bus.rf_c_reg         = reg_arr[grant_idx];
                bus.rf_c_writedatain = wdata_arr[grant_idx];
            end else begin
                bus.rf_a_en  = 1'b1;
                bus.rf_a_reg = reg_arr[grant_idx];
            end
        end
    end

    // The register file read data arrives one cycle after rf_a_en, in the
    // same cycle as the registered strobe, so it is forwarded directly.
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = (|rsp_valid_q) ? bus.rf_a_readdataout : '0;

endmodule

// File: tb/tb_vctrl_access_arbiter.sv
// Directed bench for vctrl_access_arbiter with a behavioural control register
// file (one-cycle read latency) attached to the rf_* signals.
module tb_vctrl_access_arbiter;

    localparam int W  = 32;
    localparam int L  = 5;
    localparam int NR = 3;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [W-1:0] mem [32];
    logic [W-1:0] rdata = '0;

    vctrl_access_arbiter_if #(.WIDTH(W), .LOG2NUMREGS(L), .NUMREQ(NR)) bus ();

    vctrl_access_arbiter #(
        .WIDTH(W), .LOG2NUMREGS(L), .NUMREQ(NR), .LOG2NUMREQ(2), .LOCK_MAX(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.rf_c_we) mem[bus.rf_c_reg] <= bus.rf_c_writedatain;
        if (bus.rf_a_en) rdata <= mem[bus.rf_a_reg];
    end
    assign bus.rf_a_readdataout = rdata;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_lock  = '0;
        bus.req_reg   = '0;
        bus.req_wdata = '0;
    endtask

    task automatic drive(input int i, input logic we, input logic lk,
                         input logic [L-1:0] r, input logic [W-1:0] d);
        bus.req_valid[i]       = 1'b1;
        bus.req_we[i]          = we;
        bus.req_lock[i]        = lk;
        bus.req_reg[i*L +: L]  = r;
        bus.req_wdata[i*W +: W] = d;
    endtask

    // Expected per-cycle values for the three-way read rotation.
    logic [2:0]  t3_ready [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [4:0]  t3_reg   [4] = '{5'd1, 5'd2, 5'd3, 5'd1};
    logic [2:0]  t3_rsp   [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
    logic [31:0] t3_data  [4] = '{32'h0, 32'h11, 32'hDEAD, 32'h33};

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        clr();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'h0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'h0);
        check("rst_rf_c_we", 64'(bus.rf_c_we), 64'h0);
        check("rst_rf_a_en", 64'(bus.rf_a_en), 64'h0);
        reset = 1'b0;
        tick();

        // Writes on consecutive cycles
        drive(0, 1'b1, 1'b0, 5'd0, 32'h40);
        #1;
        check("w0_ready", 64'(bus.req_ready), 64'h1);
        check("w0_we", 64'(bus.rf_c_we), 64'h1);
        check("w0_reg", 64'(bus.rf_c_reg), 64'h0);
        check("w0_data", 64'(bus.rf_c_writedatain), 64'h40);
        check("w0_a_en", 64'(bus.rf_a_en), 64'h0);
        tick();
        clr();
        drive(1, 1'b1, 1'b0, 5'd31, 32'h5);
        #1;
        check("w1_ready", 64'(bus.req_ready), 64'h2);
        check("w1_we", 64'(bus.rf_c_we), 64'h1);
        check("w1_reg", 64'(bus.rf_c_reg), 64'd31);
        check("w1_data", 64'(bus.rf_c_writedatain), 64'h5);
        check("w1_rsp", 64'(bus.rsp_valid), 64'h0);
        tick();
        clr();
        #1;
        check("w_idle_rsp", 64'(bus.rsp_valid), 64'h0);
        check("w_idle_c_we", 64'(bus.rf_c_we), 64'h0);
        check("w_mem31", 64'(mem[31]), 64'h5);

        // Read-after-write (rr_ptr=2, only req0 valid)
        drive(0, 1'b1, 1'b0, 5'd2, 32'hDEAD);
        #1;
        check("raw_w_ready", 64'(bus.req_ready), 64'h1);
        tick();
        drive(0, 1'b0, 1'b0, 5'd2, 32'h0);
        #1;
        check("raw_r_ready", 64'(bus.req_ready), 64'h1);
        check("raw_r_en", 64'(bus.rf_a_en), 64'h1);
        check("raw_r_reg", 64'(bus.rf_a_reg), 64'd2);
        check("raw_r_c_we", 64'(bus.rf_c_we), 64'h0);
        tick();
        clr();
        #1;
        check("raw_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("raw_rsp_data", 64'(bus.rsp_data), 64'hDEAD);

        // Setup: r1=0x11 via req0 (rr->1), r3=0x33 via req2 (rr->0)
        drive(0, 1'b1, 1'b0, 5'd1, 32'h11);
        #1;
        check("set1_ready", 64'(bus.req_ready), 64'h1);
        tick();
        clr();
        drive(2, 1'b1, 1'b0, 5'd3, 32'h33);
        #1;
        check("set3_ready", 64'(bus.req_ready), 64'h4);
        tick();
        clr();

        // Three-way read rotation from rr_ptr=0
        drive(0, 1'b0, 1'b0, 5'd1, 32'h0);
        drive(1, 1'b0, 1'b0, 5'd2, 32'h0);
        drive(2, 1'b0, 1'b0, 5'd3, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr_ready_%0d", k), 64'(bus.req_ready), 64'(t3_ready[k]));
            check($sformatf("rr_areg_%0d", k), 64'(bus.rf_a_reg), 64'(t3_reg[k]));
            check($sformatf("rr_rsp_%0d", k), 64'(bus.rsp_valid), 64'(t3_rsp[k]));
            if (k > 0)
                check($sformatf("rr_data_%0d", k), 64'(bus.rsp_data), 64'(t3_data[k]));
            tick();
        end
        clr();
        #1;
        check("rr_rsp_last", 64'(bus.rsp_valid), 64'h1);
        check("rr_data_last", 64'(bus.rsp_data), 64'h11);

        // Lock held by req1 across idle cycles (rr_ptr=1)
        drive(0, 1'b0, 1'b0, 5'd1, 32'h0);
        drive(1, 1'b0, 1'b1, 5'd29, 32'h0);
        drive(2, 1'b0, 1'b0, 5'd3, 32'h0);
        #1;
        check("lk_grant", 64'(bus.req_ready), 64'h2);
        check("lk_areg", 64'(bus.rf_a_reg), 64'd29);
        tick();
        bus.req_valid[1] = 1'b0;
        #1;
        check("lk_idle1_ready", 64'(bus.req_ready), 64'h0);
        check("lk_idle1_rsp", 64'(bus.rsp_valid), 64'h2);
        check("lk_idle1_data", 64'(bus.rsp_data), 64'h0);
        tick();
        check("lk_idle2_ready", 64'(bus.req_ready), 64'h0);
        check("lk_idle2_rsp", 64'(bus.rsp_valid), 64'h0);
        tick();
        drive(1, 1'b1, 1'b0, 5'd29, 32'h1234);
        #1;
        check("lk_wr_ready", 64'(bus.req_ready), 64'h2);
        check("lk_wr_we", 64'(bus.rf_c_we), 64'h1);
        check("lk_wr_reg", 64'(bus.rf_c_reg), 64'd29);
        tick();
        bus.req_valid[1] = 1'b0;
        #1;
        check("lk_after_ready", 64'(bus.req_ready), 64'h4);
        check("lk_after_rsp", 64'(bus.rsp_valid), 64'h0);
        tick();
        clr();
        #1;
        check("lk_req2_rsp", 64'(bus.rsp_valid), 64'h4);
        check("lk_req2_data", 64'(bus.rsp_data), 64'h33);
        check("lk_mem29", 64'(mem[29]), 64'h1234);

        // Lock timeout: req2 keeps req_lock=1 (rr_ptr=0)
        drive(2, 1'b0, 1'b1, 5'd3, 32'h0);
        #1;
        check("to_grant_0", 64'(bus.req_ready), 64'h4);
        tick();
        drive(0, 1'b0, 1'b0, 5'd1, 32'h0);
        for (int k = 1; k < 8; k++) begin
            #1;
            check($sformatf("to_grant_%0d", k), 64'(bus.req_ready), 64'h4);
            tick();
        end
        #1;
        check("to_release", 64'(bus.req_ready), 64'h1);
        check("to_release_areg", 64'(bus.rf_a_reg), 64'd1);
        tick();
        clr();
        #1;
        check("to_req0_rsp", 64'(bus.rsp_valid), 64'h1);
        check("to_req0_data", 64'(bus.rsp_data), 64'h11);
        tick();

        // Reset during a locked read (rr_ptr=1)
        drive(1, 1'b0, 1'b1, 5'd29, 32'h0);
        #1;
        check("rr6_grant", 64'(bus.req_ready), 64'h2);
        tick();
        drive(0, 1'b0, 1'b0, 5'd1, 32'h0);
        #1;
        check("rr6_locked", 64'(bus.req_ready), 64'h2);
        check("rr6_rsp_pre", 64'(bus.rsp_valid), 64'h2);
        reset = 1'b1;
        #1;
        check("rr6_unlock_async", 64'(bus.req_ready), 64'h1);
        check("rr6_rsp_async", 64'(bus.rsp_valid), 64'h0);
        tick();
        check("rr6_rsp_held", 64'(bus.rsp_valid), 64'h0);
        check("rr6_data_held", 64'(bus.rsp_data), 64'h0);
        reset = 1'b0;
        clr();
        #1;
        check("rr6_idle_ready", 64'(bus.req_ready), 64'h0);
        tick();
        check("rr6_idle_rsp", 64'(bus.rsp_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
